// File: rtl/cgra_pkg.sv
// Shared CGRA definitions.
// Holds the skid-stage state encoding and its depth. The state encoding
// doubles as the occupancy count of the stage.
package cgra_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH = 2;

endpackage : cgra_pkg

// File: rtl/reg_ar_en.sv
// Load-enabled register with asynchronous active-high clear.
// Ports:
//   clk - rising-edge clock
//   rst - async active-high clear, q goes to zero
//   en  - load d on the next rising edge
//   d   - data in
//   q   - registered data out
module reg_ar_en #(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule : reg_ar_en

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a two-entry skid buffer.
// Accepts one beat per cycle while the downstream keeps up and parks one
// extra beat in the skid register when the downstream stalls. All outputs
// come straight from flops, so m_ready never reaches s_ready combinationally.
// Ports:
//   clk, rst  - clock, async active-high reset
//   s_data    - upstream payload
//   s_valid   - upstream beat valid
//   s_ready   - stage can accept a beat (registered)
//   m_data    - downstream payload (registered)
//   m_valid   - downstream beat valid (registered)
//   m_ready   - downstream accepts beat
//   occupancy - number of beats held (0..2)
module pipe_skid_reg
    import cgra_pkg::*;
#(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       occupancy
);

    skid_state_t      state_q;
    logic             s_ready_q;
    logic             m_valid_q;
    logic [width-1:0] main_q;
    logic [width-1:0] main_d;
    logic [width-1:0] skid_q;
    logic             main_en;
    logic             skid_en;
    logic             s_fire;
    logic             m_fire;

    assign s_fire = s_valid & s_ready_q;
    assign m_fire = m_valid_q & m_ready;

    // Main register loads fresh upstream data when empty or when a beat
    // leaves and another arrives together; when the skid is occupied it
    // refills from the skid as the head beat departs.
    assign main_en = ((state_q == EMPTY) && s_fire)
                   || ((state_q == BUSY) && s_fire && m_fire)
                   || ((state_q == FULL) && m_fire);
    assign main_d  = (state_q == FULL) ? skid_q : s_data;

    // Skid captures the beat that arrived while the head beat stalled.
    assign skid_en = (state_q == BUSY) && s_fire && !m_fire;

    reg_ar_en #(.width(width)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    reg_ar_en #(.width(width)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (s_data),
        .q   (skid_q)
    );

    // s_ready is held low through reset and rises on the first edge after
    // release, since EMPTY always reasserts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    s_ready_q <= 1'b1;
                    if (s_fire) begin
                        state_q   <= BUSY;
                        m_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (s_fire && !m_fire) begin
                        state_q   <= FULL;
                        s_ready_q <= 1'b0;
                    end else if (!s_fire && m_fire) begin
                        state_q   <= EMPTY;
                        m_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (m_fire) begin
                        state_q   <= BUSY;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    m_valid_q <= 1'b0;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = main_q;
    assign occupancy = state_q;

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.width(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [63:0] sd;
        logic        mr;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  eo;
        logic        esr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic sv, input logic [63:0] sd, input logic mr,
                                input logic ev, input logic [63:0] ed,
                                input logic [1:0] eo, input logic esr);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr; v.ev = ev; v.ed = ed; v.eo = eo; v.esr = esr;
        vecs.push_back(v);
    endfunction

    logic [63:0] q[$];
    logic [63:0] seq;
    logic [63:0] prev_data;
    logic        prev_hold;
    logic        sr_before;
    logic        sf, mf;
    int          beats;
    int          cyc;

    initial begin
        // Expected outputs after the edge that follows each input set.
        // Streaming 0x1..0x10 with m_ready high.
        for (int k = 1; k <= 16; k++) add(1'b1, 64'(k), 1'b1, 1'b1, 64'(k), 2'd1, 1'b1);
        add(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1);
        // Backpressure: 0xA then 0xB, with a refused 0xC while full.
        add(1'b1, 64'hA, 1'b0, 1'b1, 64'hA, 2'd1, 1'b1);
        add(1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 2'd2, 1'b0);
        add(1'b0, 64'h0, 1'b0, 1'b1, 64'hA, 2'd2, 1'b0);
        add(1'b1, 64'hC, 1'b0, 1'b1, 64'hA, 2'd2, 1'b0);
        add(1'b1, 64'hC, 1'b1, 1'b1, 64'hB, 2'd1, 1'b1);
        add(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1);
        // Simultaneous fire in BUSY.
        add(1'b1, 64'h5, 1'b0, 1'b1, 64'h5, 2'd1, 1'b1);
        add(1'b1, 64'h6, 1'b1, 1'b1, 64'h6, 2'd1, 1'b1);
        add(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1);

        rst = 1'b1; s_valid = 1'b1; s_data = 64'hDEAD; m_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_s_ready", 64'(s_ready), 64'h0);
            chk("rst_m_valid", 64'(m_valid), 64'h0);
            chk("rst_m_data", m_data, 64'h0);
            chk("rst_occ", 64'(occupancy), 64'h0);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rel_s_ready_low", 64'(s_ready), 64'h0);
        @(posedge clk); #1;
        chk("rel_s_ready", 64'(s_ready), 64'h1);
        chk("rel_m_valid", 64'(m_valid), 64'h0);
        chk("rel_occ", 64'(occupancy), 64'h0);

        foreach (vecs[i]) begin
            s_valid = vecs[i].sv; s_data = vecs[i].sd; m_ready = vecs[i].mr;
            @(posedge clk); #1;
            chk($sformatf("v%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) chk($sformatf("v%0d_m_data", i), m_data, vecs[i].ed);
            chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].eo));
            chk($sformatf("v%0d_s_ready", i), 64'(s_ready), 64'(vecs[i].esr));
        end

        // Random valid/ready with scoreboard.
        seq = 64'h1000; beats = 0; cyc = 0; prev_hold = 1'b0; prev_data = '0;
        while (beats < 10000 && cyc < 60000) begin
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 6);
            s_data  = seq;
            sr_before = s_ready;
            m_ready = ~m_ready; #1;
            chk("comb_s_ready", 64'(s_ready), 64'(sr_before));
            m_ready = ~m_ready; #1;
            sf = s_valid & s_ready;
            mf = m_valid & m_ready;
            if (mf) begin
                if (q.size() == 0) chk("rnd_unexpected_beat", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("rnd_order", m_data, q.pop_front());
                beats++;
            end
            if (sf) begin
                q.push_back(seq);
                seq++;
            end
            prev_hold = m_valid & ~m_ready;
            prev_data = m_data;
            @(posedge clk); #1;
            cyc++;
            chk("rnd_occ", 64'(occupancy), 64'(q.size()));
            chk("rnd_s_ready", 64'(s_ready), 64'(q.size() != 2));
            if (prev_hold) begin
                chk("rnd_hold_valid", 64'(m_valid), 64'h1);
                chk("rnd_hold_data", m_data, prev_data);
            end
        end
        chk("rnd_done_in_budget", 64'(beats >= 10000), 64'h1);

        // Drain, then build up FULL and hit it with async reset between edges.
        s_valid = 1'b0; m_ready = 1'b1;
        cyc = 0;
        while (m_valid && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("drain_empty", 64'(m_valid), 64'h0);
        s_valid = 1'b1; s_data = 64'h77; m_ready = 1'b0;
        @(posedge clk); #1;
        s_data = 64'h88;
        @(posedge clk); #1;
        chk("full_occ", 64'(occupancy), 64'h2);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'h0);
        chk("arst_occ", 64'(occupancy), 64'h0);
        chk("arst_s_ready", 64'(s_ready), 64'h0);
        chk("arst_m_data", m_data, 64'h0);
        @(negedge clk); rst = 1'b0; m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_arst_m_valid", 64'(m_valid), 64'h0);
            chk("post_arst_occ", 64'(occupancy), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Elastic pipeline register stage with a valid/ready handshake on both sides. It is the flow-controlled counterpart of the plain free-running pipeline register: it sits between CGRA processing elements or between the CGRA and the stream interface, and absorbs downstream backpressure without dropping or duplicating data. A two-entry skid buffer gives full throughput, one beat per cycle. Every output is driven from a flop, so no combinational path exists from m_ready to s_ready.

Parameters:
width, 64, payload width in bits.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
s_data  input  width  upstream payload.
s_valid  input  1  upstream beat valid.
s_ready  output  1  stage can accept a beat; registered.
m_data  output  width  downstream payload; registered.
m_valid  output  1  downstream beat valid; registered.
m_ready  input  1  downstream accepts beat.
occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Handshake definitions: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- Upstream may change s_data whenever s_fire is low.
- Once asserted, m_valid stays high and m_data stays stable until m_fire.
- Reset (async assert, sync release):
  - state=EMPTY, m_valid=0, m_data='0, skid='0, occupancy=0, s_ready=0.
  - s_ready rises on the first rising edge after rst deasserts.
- States: EMPTY (occupancy 0), BUSY (main register full), FULL (main and skid registers full).
- Transitions:
  - EMPTY: s_fire -> main<=s_data, m_valid<=1, go BUSY.
  - BUSY: s_fire & !m_fire -> skid<=s_data, s_ready<=0, go FULL.
  - BUSY: s_fire & m_fire -> main<=s_data, stay BUSY (1 beat/cycle throughput).
  - BUSY: !s_fire & m_fire -> m_valid<=0, go EMPTY.
  - BUSY: no fire -> hold.
  - FULL: m_fire -> main<=skid, s_ready<=1, go BUSY. s_fire is impossible in FULL because s_ready=0.
  - FULL: no m_fire -> hold.
- Latency: a beat accepted at edge N is presented on m_data/m_valid after edge N. Minimum latency is 1 cycle.
- Ordering: strict FIFO order; no beat is lost or duplicated.
- s_ready is low exactly in FULL, and during reset.
- occupancy equals the state encoding. Illegal state encoding recovers to EMPTY.
- s_valid while s_ready=0 is not a transfer; data is ignored.
- Reset mid-operation discards all held beats immediately, asynchronously, with no partial output.
- Payload is carried unmodified; no arithmetic.

Decomposition:
- Shared package cgra_pkg holds:
  - typedef enum logic [1:0] skid_state_t {EMPTY=0, BUSY=1, FULL=2}.
  - Localparam SKID_DEPTH=2.
- One sub-module, reg_ar_en (width parameter; clk, rst async, en, d, q), is instantiated twice: main register and skid register.
- The state machine and the ready/valid flops stay in pipe_skid_reg.

Test Plan:
- Reset release: rst high 3 cycles with s_valid=1 -> s_ready=0, m_valid=0, m_data=0, occupancy=0 throughout; s_ready=1 one edge after release.
- Streaming: m_ready=1, send 0x1..0x10 back-to-back -> m_data emits 0x1..0x10 in order, one per cycle, first beat 1 cycle after acceptance; occupancy stays 1.
- Backpressure: m_ready=0, send 0xA then 0xB -> occupancy 2, s_ready=0, m_data holds 0xA. Raise m_ready -> 0xA, then 0xB emitted; s_ready returns to 1 after the first m_fire.
- Simultaneous fire in BUSY: main=0x5, s_data=0x6, s_valid=m_ready=1 -> next cycle m_data=0x6, m_valid=1, occupancy 1.
- Random valid/ready toggling, 10k beats, scoreboard -> zero loss or duplication. Assertions hold: m_data stable while m_valid&!m_ready; s_ready never a comb function of m_ready.
- Async reset mid-FULL (two beats held, asserted between edges) -> m_valid=0 and occupancy=0 immediately without waiting for an edge; the held beats never appear after release.
